// File: rtl/arb_types.sv
// Types and constants shared by the I/D memory arbiter and its round-robin chooser.
package arb_types;
  localparam int unsigned ARB_LINE_W = 256;
  localparam logic [31:0] ARB_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == ARB_CNT_MAX) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I scalar types; the arbiter reuses the word type for line addresses.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin chooser: on contention the side that was not served last wins.
module arb_rr_pick (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic grant_i,
  output logic grant_d
);
  always_comb begin
    grant_d = req_d & (~req_i | ~last_d);
    grant_i = req_i & (~req_d | last_d);
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction- and data-cache line ports onto one downstream line port.
// Handshake: a requester raises *_read/*_write with stable operands and holds them until
// its *_resp pulses for one cycle; it drops them the cycle after. Dropped early = result discarded.
module mem_arbiter
  import arb_types::*, rv32i_types::*;
#(
  parameter int unsigned LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  rv32i_word         i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  rv32i_word         d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output rv32i_word         mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       arb_conflicts,
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  rv32i_word         mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [31:0]       conflicts_q, conflicts_d;

  logic d_req;
  logic pick_i, pick_d;

  assign d_req = d_read | d_write;

  arb_rr_pick u_pick (
    .req_i   (i_read),
    .req_d   (d_req),
    .last_d  (last_d_q),
    .grant_i (pick_i),
    .grant_d (pick_d)
  );

  // The mem_* registers double as the grant-time latches: loaded at grant, cleared on return to idle.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    conflicts_d = conflicts_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_d) begin
          state_d     = ARB_SERVE_D;
          mem_addr_d  = d_addr;
          mem_write_d = d_write;
          mem_read_d  = d_read & ~d_write;
          mem_wdata_d = d_wdata;
        end else if (pick_i) begin
          state_d     = ARB_SERVE_I;
          mem_addr_d  = i_addr;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_wdata_d = '0;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (mem_resp) begin
          state_d     = ARB_IDLE;
          last_d_d    = (state_q == ARB_SERVE_D);
          mem_addr_d  = '0;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b0;
          mem_wdata_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // I is stalled behind D (or behind the idle turnaround) while both want the port.
    if (i_read && d_req && (state_q != ARB_SERVE_I)) begin
      conflicts_d = sat_inc(conflicts_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      conflicts_q <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      conflicts_q <= conflicts_d;
    end
  end

  always_comb begin
    i_resp  = (state_q == ARB_SERVE_I) & mem_resp & i_read;
    d_resp  = (state_q == ARB_SERVE_D) & mem_resp & d_req;
    i_rdata = i_resp ? mem_rdata : '0;
    d_rdata = d_resp ? mem_rdata : '0;
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign arb_conflicts = conflicts_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, per-cycle compare, directed and random traffic.
module tb_mem_arbiter;
  import arb_types::*;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [31:0]   i_addr = '0, d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [31:0]   mem_addr, arb_conflicts;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  arb_state_t    dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .arb_conflicts(arb_conflicts), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model: who owns the port and what was latched ----------------
  int            m_busy   = 0;   // 0 nobody, 1 I-cache, 2 D-cache
  logic [31:0]   m_addr   = '0;
  logic          m_rd     = 1'b0, m_wr = 1'b0, m_last_d = 1'b0;
  logic [LW-1:0] m_wdata  = '0;
  longint        m_hits   = 0;   // qualifying contention cycles since reset, unbounded
  longint        cnt_base = 0;
  longint        hits_at_force = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_addr <= '0; m_rd <= 1'b0; m_wr <= 1'b0; m_wdata <= '0;
      m_last_d <= 1'b0; m_hits <= 0;
    end else begin
      if (i_read && (d_read || d_write) && m_busy != 1) m_hits <= m_hits + 1;
      if (m_busy == 0) begin
        if ((d_read || d_write) && (!i_read || !m_last_d)) begin
          m_busy <= 2; m_addr <= d_addr; m_wr <= d_write; m_rd <= d_read && !d_write; m_wdata <= d_wdata;
        end else if (i_read) begin
          m_busy <= 1; m_addr <= i_addr; m_rd <= 1'b1; m_wr <= 1'b0; m_wdata <= '0;
        end
      end else if (mem_resp) begin
        m_last_d <= (m_busy == 2);
        m_busy <= 0; m_addr <= '0; m_rd <= 1'b0; m_wr <= 1'b0; m_wdata <= '0;
      end
    end
  end

  function automatic logic [31:0] exp_cnt();
    longint v;
    v = cnt_base + (m_hits - hits_at_force);
    return (v > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_ir, e_dr;
    arb_state_t e_st;
    e_ir = (m_busy == 1) && mem_resp && i_read;
    e_dr = (m_busy == 2) && mem_resp && (d_read || d_write);
    e_st = (m_busy == 1) ? ARB_SERVE_I : (m_busy == 2) ? ARB_SERVE_D : ARB_IDLE;
    chk("state", dbg_state, e_st);
    chk("mem_read", mem_read, m_busy != 0 && m_rd);
    chk("mem_write", mem_write, m_busy == 2 && m_wr);
    chk("mem_addr", mem_addr, (m_busy != 0) ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata, (m_busy == 2) ? m_wdata : '0);
    chk("i_resp", i_resp, e_ir);
    chk("i_rdata", i_rdata, e_ir ? mem_rdata : '0);
    chk("d_resp", d_resp, e_dr);
    chk("d_rdata", d_rdata, e_dr ? mem_rdata : '0);
    chk("arb_conflicts", arb_conflicts, exp_cnt());
  end

  // ---------------- grant-order scoreboard ----------------
  logic [1:0] exp_q[$];
  arb_state_t prev_st = ARB_IDLE;

  always @(negedge clk) begin
    if (dbg_state != prev_st && dbg_state != ARB_IDLE && exp_q.size() > 0)
      chk("grant_order", dbg_state, exp_q.pop_front());
    prev_st <= dbg_state;
  end

  // ---------------- downstream responder ----------------
  int            lat = 2;
  bit            rand_lat = 1'b0;
  bit            spur = 1'b0;
  logic [LW-1:0] next_rdata = '0;

  initial begin
    int l, n;
    bit ok;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (spur) begin
        @(posedge clk); #1 mem_resp = 1'b1; mem_rdata = next_rdata;
        @(posedge clk); #1 mem_resp = 1'b0; mem_rdata = '0;
        spur = 1'b0;
      end else if (rst && (mem_read || mem_write)) begin
        l  = rand_lat ? $urandom_range(1, 4) : lat;
        ok = 1'b1;
        n  = 1;
        while (ok && n < l) begin
          @(posedge clk);
          if (!rst) ok = 1'b0;
          n++;
        end
        #1;
        if (ok && rst) begin
          mem_resp = 1'b1; mem_rdata = next_rdata;
          @(posedge clk); #1 mem_resp = 1'b0; mem_rdata = '0;
          next_rdata = rand_line();
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic do_i(input logic [31:0] addr, input int hold, output bit got);
    int n;
    got = 1'b0;
    @(posedge clk); #1 i_read = 1'b1; i_addr = addr;
    n = 0;
    while (!got && n < hold) begin
      @(negedge clk);
      if (i_resp) got = 1'b1;
      n++;
    end
    @(posedge clk); #1 i_read = 1'b0; i_addr = $urandom;
  endtask

  task automatic do_d(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [LW-1:0] wd, input int hold, output bit got);
    int n;
    got = 1'b0;
    @(posedge clk); #1 d_read = rd; d_write = wr; d_addr = addr; d_wdata = wd;
    n = 0;
    while (!got && n < hold) begin
      @(negedge clk);
      if (d_resp) got = 1'b1;
      n++;
    end
    @(posedge clk); #1 d_read = 1'b0; d_write = 1'b0; d_addr = $urandom; d_wdata = rand_line();
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b0; cnt_base = 0; hits_at_force = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dbg_state != ARB_IDLE && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, dbg_state == ARB_IDLE, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  bit got_i, got_d;
  logic [LW-1:0] wline;

  initial begin
    int mode, dly_i, dly_d, hold_i, hold_d;
    logic rd, wr;

    repeat (2) @(negedge clk);
    chk("rst_state", dbg_state, ARB_IDLE);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_i_resp", i_resp, 1'b0);
    chk("rst_conflicts", arb_conflicts, 32'h0);
    #2 rst = 1'b1;

    // single I read, response three cycles after the grant becomes visible
    next_rdata = {32{8'hA5}};
    lat = 3;
    exp_q.push_back(ARB_SERVE_I);
    @(posedge clk); #1 i_read = 1'b1; i_addr = 32'h0000_0040;
    @(negedge clk); chk("r25_no_grant_yet", mem_read, 1'b0);
    @(negedge clk); chk("r25_mem_read", mem_read, 1'b1);
    chk("r25_mem_addr", mem_addr, 32'h40);
    chk("r25_d_resp_c1", d_resp, 1'b0);
    @(negedge clk); chk("r25_i_resp_c2", i_resp, 1'b0);
    @(negedge clk); chk("r25_i_resp", i_resp, 1'b1);
    chk("r25_i_rdata", i_rdata, {32{8'hA5}});
    chk("r25_d_resp", d_resp, 1'b0);
    @(posedge clk); #1 i_read = 1'b0;

    // simultaneous I and D right after reset: D first, I waits three cycles
    do_reset();
    lat = 2;
    wline = {8{32'h1234_5678}};
    exp_q.push_back(ARB_SERVE_D);
    exp_q.push_back(ARB_SERVE_I);
    fork
      do_i(32'h0000_2000, 200, got_i);
      do_d(32'h0000_1000, 1'b0, 1'b1, wline, 200, got_d);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("r26_mem_write", mem_write, 1'b1);
        chk("r26_mem_read", mem_read, 1'b0);
        chk("r26_mem_addr", mem_addr, 32'h1000);
        chk("r26_mem_wdata", mem_wdata, wline);
      end
    join
    chk("r26_got_i", got_i, 1'b1);
    chk("r26_got_d", got_d, 1'b1);
    @(negedge clk); chk("r26_conflicts", arb_conflicts, 32'd3);

    // continuous traffic from both sides alternates
    exp_q.push_back(ARB_SERVE_D);
    exp_q.push_back(ARB_SERVE_I);
    exp_q.push_back(ARB_SERVE_D);
    exp_q.push_back(ARB_SERVE_I);
    fork
      begin
        do_i(32'h0000_4000, 200, got_i); chk("r27_got_i0", got_i, 1'b1);
        do_i(32'h0000_4040, 200, got_i); chk("r27_got_i1", got_i, 1'b1);
      end
      begin
        do_d(32'h0000_5000, 1'b1, 1'b0, '0, 200, got_d); chk("r27_got_d0", got_d, 1'b1);
        do_d(32'h0000_5040, 1'b0, 1'b1, rand_line(), 200, got_d); chk("r27_got_d1", got_d, 1'b1);
      end
    join
    chk("r27_order_done", exp_q.size(), 0);

    // spurious response while idle
    repeat (2) @(negedge clk);
    @(posedge clk); #1 spur = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("r29_i_resp", i_resp, 1'b0);
    chk("r29_d_resp", d_resp, 1'b0);
    chk("r29_i_rdata", i_rdata, '0);
    chk("r29_state", dbg_state, ARB_IDLE);
    @(negedge clk); chk("r29_state_after", dbg_state, ARB_IDLE);

    // reset two cycles into a D write
    do_reset();
    lat = 8;
    @(posedge clk); #1 i_read = 1'b1; d_write = 1'b1; d_addr = 32'h3000; d_wdata = rand_line();
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("r28_pre_write", mem_write, 1'b1);
    chk("r28_pre_conflicts", arb_conflicts, 32'd2);
    #1 rst = 1'b0; cnt_base = 0; hits_at_force = 0;
    #1;
    chk("r28_mem_write", mem_write, 1'b0);
    chk("r28_d_resp", d_resp, 1'b0);
    chk("r28_conflicts", arb_conflicts, 32'h0);
    chk("r28_mem_addr", mem_addr, 32'h0);
    chk("r28_state", dbg_state, ARB_IDLE);
    i_read = 1'b0; d_write = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    lat = 2;
    exp_q.push_back(ARB_SERVE_I);
    do_i(32'h0000_0080, 200, got_i);
    chk("r28_fresh_i", got_i, 1'b1);

    // saturation of the contention counter
    do_reset();
    @(negedge clk);
    #2 force dut.conflicts_q = 32'hFFFF_FFFE;
    cnt_base = 64'sh0000_0000_FFFF_FFFE;
    hits_at_force = m_hits;
    #1 release dut.conflicts_q;
    @(negedge clk); chk("r30_forced", arb_conflicts, 32'hFFFF_FFFE);
    lat = 3;
    exp_q.push_back(ARB_SERVE_D);
    exp_q.push_back(ARB_SERVE_I);
    fork
      do_i(32'h0000_6000, 200, got_i);
      do_d(32'h0000_7000, 1'b1, 1'b0, '0, 200, got_d);
    join
    chk("r30_sat", arb_conflicts, 32'hFFFF_FFFF);

    // randomized traffic, including early drops and stray responses
    rand_lat = 1'b1;
    for (int it = 0; it < 60; it++) begin
      mode   = $urandom_range(0, 2);
      dly_i  = $urandom_range(0, 3);
      dly_d  = $urandom_range(0, 3);
      hold_i = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 200;
      hold_d = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 200;
      wr     = $urandom_range(0, 1);
      rd     = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      got_i  = 1'b0;
      got_d  = 1'b0;
      fork
        if (mode != 1) begin
          repeat (dly_i) @(posedge clk);
          do_i($urandom, hold_i, got_i);
        end
        if (mode != 0) begin
          repeat (dly_d) @(posedge clk);
          do_d($urandom, rd, wr, rand_line(), hold_d, got_d);
        end
      join
      if (mode != 1 && hold_i == 200) chk("rand_got_i", got_i, 1'b1);
      if (mode != 0 && hold_d == 200) chk("rand_got_d", got_d, 1'b1);
      wait_idle("rand_idle");
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1 spur = 1'b1;
        repeat (4) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
